// File: rtl/led_pwm_fader_if.sv
// -----------------------------------------------------------------------------
// led_pwm_fader_if
// Groups the PIO-side pattern/control signals and the LED-side drive/status
// signals of the LED PWM fader into one bundle.
//
// Signals:
//   led_in        target on/off pattern from the PIO (1 = fade on)
//   global_level  global brightness scale, 255 = full
//   enable        1 = run, 0 = freeze counters and blank outputs
//   led_out       PWM drive to the LED pins (1 = lit)
//   busy          1 while any channel is still ramping toward its target
//   period_strobe one-cycle pulse at the end of each PWM period
//
// Modports:
//   master  the PIO/system side, drives pattern and control
//   slave   the fader itself, drives LED outputs and status
// -----------------------------------------------------------------------------
interface led_pwm_fader_if #(
  parameter int NUM_LEDS = 8
);

  logic [NUM_LEDS-1:0] led_in;
  logic [7:0]          global_level;
  logic                enable;
  logic [NUM_LEDS-1:0] led_out;
  logic                busy;
  logic                period_strobe;

  modport master (
    output led_in,
    output global_level,
    output enable,
    input  led_out,
    input  busy,
    input  period_strobe
  );

  modport slave (
    input  led_in,
    input  global_level,
    input  enable,
    output led_out,
    output busy,
    output period_strobe
  );

endinterface

// File: rtl/led_pwm_fader.sv
// -----------------------------------------------------------------------------
// led_pwm_fader
// Takes the on/off LED pattern written by the processor into the PIO and
// renders it on the LED pins as 8-bit PWM. Each channel ramps its brightness
// level up or down one step at a time toward fully on or fully off, and the
// rendered duty is scaled by a global dimming level.
//
// Ports:
//   clk    system clock (same domain as the PIO)
//   reset  synchronous, active-high reset
//   bus    led_pwm_fader_if slave modport:
//            led_in, global_level, enable   (inputs)
//            led_out, busy, period_strobe   (outputs, all registered)
//
// Parameters:
//   NUM_LEDS  number of LED channels
//   PRESCALE  clk cycles per PWM tick, 1..65535
//   FADE_DIV  PWM periods per brightness step, 1..255
// -----------------------------------------------------------------------------
module led_pwm_fader #(
  parameter int NUM_LEDS = 8,
  parameter int PRESCALE = 256,
  parameter int FADE_DIV = 1
) (
  input  logic               clk,
  input  logic               reset,
  led_pwm_fader_if.slave     bus
);

  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);
  localparam logic [7:0]  FADE_LAST     = 8'(FADE_DIV - 1);

  logic [15:0]         prescaler;
  logic [7:0]          pwm_cnt;
  logic [7:0]          fade_cnt;
  logic [7:0]          level [NUM_LEDS];
  logic [7:0]          duty  [NUM_LEDS];
  logic [NUM_LEDS-1:0] led_next;
  logic                busy_next;
  logic                tick;
  logic                period_end;
  logic                step;

  // Timebase qualifiers. Everything is gated by enable so that a frozen
  // fader neither ticks, ends a period nor steps a level.
  assign tick       = bus.enable & (prescaler == PRESCALE_LAST);
  assign period_end = tick & (pwm_cnt == 8'hFF);
  assign step       = period_end & (fade_cnt == FADE_LAST);

  // Prescaler, PWM counter and fade divider. All hold their value while
  // enable is low so a resumed fader continues mid-period.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
      fade_cnt  <= '0;
    end else if (bus.enable) begin
      if (prescaler == PRESCALE_LAST) begin
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + 16'd1;
      end
      if (tick) begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
      if (period_end) begin
        if (fade_cnt == FADE_LAST) begin
          fade_cnt <= '0;
        end else begin
          fade_cnt <= fade_cnt + 8'd1;
        end
      end
    end
  end

  // Per-channel brightness ramp. led_in is sampled right at the step edge,
  // so a pattern change simply reverses direction from the current level.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        level[i] <= '0;
      end
    end else if (step) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (bus.led_in[i] && (level[i] != 8'hFF)) begin
          level[i] <= level[i] + 8'd1;
        end else if (!bus.led_in[i] && (level[i] != 8'h00)) begin
          level[i] <= level[i] - 8'd1;
        end
      end
    end
  end

  // Duty scaling and next-state of the registered outputs. The upper byte of
  // level*global_level is used, except that full scale passes level through
  // unchanged so a fully-on channel at full brightness stays constantly lit.
  always_comb begin
    duty      = '{default: '0};
    led_next  = '0;
    busy_next = 1'b0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (bus.global_level == 8'hFF) begin
        duty[i] = level[i];
      end else begin
        duty[i] = 8'((16'(level[i]) * 16'(bus.global_level)) >> 8);
      end
      led_next[i] = bus.enable & ((pwm_cnt < duty[i]) | (duty[i] == 8'hFF));
      if (level[i] != (bus.led_in[i] ? 8'hFF : 8'h00)) begin
        busy_next = 1'b1;
      end
    end
  end

  // Output registers: one clk of latency from counter/level/scale changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.led_out       <= '0;
      bus.busy          <= 1'b0;
      bus.period_strobe <= 1'b0;
    end else begin
      bus.led_out       <= led_next;
      bus.busy          <= busy_next;
      bus.period_strobe <= period_end;
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// -----------------------------------------------------------------------------
// tb_led_pwm_fader
// Directed bench for led_pwm_fader. dut_a (PRESCALE=1, FADE_DIV=1) carries
// the ramp, duty, scaling, reversal and freeze scenarios; dut_b (PRESCALE=3,
// FADE_DIV=2) exercises a non-trivial prescaler and fade divider. Lit-cycle
// counts per PWM window are predicted from a level model and queued before
// each window, then popped and compared when the window's strobe arrives.
// -----------------------------------------------------------------------------
module tb_led_pwm_fader;

  localparam int NL = 8;

  logic clk = 1'b0;
  logic reset;

  int tests = 0;
  int failures = 0;
  int exp_q[$];
  int a_level = 0;
  int b_level = 0;
  int b_fade = 0;

  led_pwm_fader_if #(.NUM_LEDS(NL)) a_if ();
  led_pwm_fader_if #(.NUM_LEDS(NL)) b_if ();

  led_pwm_fader #(.NUM_LEDS(NL), .PRESCALE(1), .FADE_DIV(1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if.slave)
  );

  led_pwm_fader #(.NUM_LEDS(NL), .PRESCALE(3), .FADE_DIV(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.slave)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Expected brightness ramp for one step
  function automatic int nextLevel(input int lvl, input logic on);
    if (on && lvl < 255) return lvl + 1;
    if (!on && lvl > 0) return lvl - 1;
    return lvl;
  endfunction

  // Expected lit clk cycles in one PWM window
  function automatic int litCycles(input int lvl, input int gl, input int ps);
    int d;
    d = (gl == 255) ? lvl : (lvl * gl) / 256;
    return (d == 255) ? 256 * ps : d * ps;
  endfunction

  task automatic checkOutput(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NL-1:0] pattern, input logic [7:0] gl, input logic en);
    a_if.led_in       = pattern;
    a_if.global_level = gl;
    a_if.enable       = en;
  endtask

  // Collects one PWM window (first cycle after a strobe up to and including
  // the next strobe), bounded so a dead strobe cannot hang the run.
  task automatic waitPeriod(input int which, output int hi, output int cyc,
                            output logic first_busy, output logic others);
    logic strobe;
    hi = 0; cyc = 0; first_busy = 1'b0; others = 1'b0; strobe = 1'b0;
    while (!strobe && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (which == 0) begin
        hi += int'(a_if.led_out[0]);
        others |= |a_if.led_out[NL-1:1];
        strobe = a_if.period_strobe;
        if (cyc == 1) first_busy = a_if.busy;
      end else begin
        hi += int'(b_if.led_out[0]);
        others |= |b_if.led_out[NL-1:1];
        strobe = b_if.period_strobe;
        if (cyc == 1) first_busy = b_if.busy;
      end
    end
    if (!strobe) checkOutput("strobe_timeout", int'(strobe), 1);
  endtask

  task automatic aPeriod(input string tag);
    int hi, cyc, exp, exp_busy;
    logic fb, oth;
    exp_busy = (a_level != (a_if.led_in[0] ? 255 : 0)) ? 1 : 0;
    exp_q.push_back(litCycles(a_level, int'(a_if.global_level), 1));
    waitPeriod(0, hi, cyc, fb, oth);
    exp = exp_q.pop_front();
    checkOutput({tag, "_lit"}, hi, exp);
    checkOutput({tag, "_len"}, cyc, 256);
    checkOutput({tag, "_busy"}, int'(fb), exp_busy);
    checkOutput({tag, "_others"}, int'(oth), 0);
    a_level = nextLevel(a_level, a_if.led_in[0]);
  endtask

  task automatic bAdvance();
    if (b_fade == 1) begin
      b_fade = 0;
      b_level = nextLevel(b_level, 1'b1);
    end else begin
      b_fade++;
    end
  endtask

  task automatic bPeriod(input string tag);
    int hi, cyc, exp;
    logic fb, oth;
    exp_q.push_back(litCycles(b_level, 255, 3));
    waitPeriod(1, hi, cyc, fb, oth);
    exp = exp_q.pop_front();
    checkOutput({tag, "_lit"}, hi, exp);
    checkOutput({tag, "_len"}, cyc, 768);
    bAdvance();
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_a_led"}, int'(a_if.led_out), 0);
    checkOutput({tag, "_a_busy"}, int'(a_if.busy), 0);
    checkOutput({tag, "_a_strobe"}, int'(a_if.period_strobe), 0);
    checkOutput({tag, "_b_led"}, int'(b_if.led_out), 0);
    checkOutput({tag, "_b_busy"}, int'(b_if.busy), 0);
  endtask

  // Directed sequence
  initial begin
    int hi, cyc;
    logic fb, oth, strobe_seen, lit_seen;

    reset = 1'b1;
    applyStimulus(8'h01, 8'hFF, 1'b1);
    b_if.led_in       = 8'h01;
    b_if.global_level = 8'hFF;
    b_if.enable       = 1'b1;
    repeat (3) @(negedge clk);
    checkReset("reset_init");

    // Prescaler 3 / fade divider 2: level steps every second period
    reset = 1'b0;
    waitPeriod(1, hi, cyc, fb, oth);
    bAdvance();
    for (int i = 0; i < 4; i++) bPeriod("b_ramp");

    // Restart dut_a and ramp it to level 40
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    a_level = 0;
    waitPeriod(0, hi, cyc, fb, oth);
    a_level = nextLevel(a_level, 1'b1);
    while (a_level < 40) aPeriod("fade_in");

    // Reset mid-fade: outputs clear at the first edge, ramp restarts from 0
    reset = 1'b1;
    @(negedge clk);
    checkReset("reset_mid");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    a_level = 0;
    waitPeriod(0, hi, cyc, fb, oth);
    a_level = nextLevel(a_level, 1'b1);
    while (a_level < 10) aPeriod("restart");

    // Reverse at level 10 and fade fully out
    applyStimulus(8'h00, 8'hFF, 1'b1);
    while (a_level > 0) aPeriod("reverse");
    aPeriod("off_hold");

    // Busy rises one cycle after a mismatching pattern change
    applyStimulus(8'h01, 8'hFF, 1'b1);
    while (a_level < 50) aPeriod("ramp50");

    // Freeze at level 50 with pwm_cnt held at 20
    repeat (20) @(negedge clk);
    checkOutput("pre_freeze_lit", int'(a_if.led_out[0]), 1);
    applyStimulus(8'h01, 8'hFF, 1'b0);
    @(negedge clk);
    checkOutput("freeze_blank", int'(a_if.led_out), 0);
    strobe_seen = 1'b0;
    lit_seen = 1'b0;
    for (int i = 0; i < 999; i++) begin
      @(negedge clk);
      strobe_seen |= a_if.period_strobe;
      lit_seen |= |a_if.led_out;
    end
    checkOutput("freeze_no_strobe", int'(strobe_seen), 0);
    checkOutput("freeze_stays_dark", int'(lit_seen), 0);
    checkOutput("freeze_busy", int'(a_if.busy), 1);
    applyStimulus(8'h01, 8'hFF, 1'b1);
    waitPeriod(0, hi, cyc, fb, oth);
    checkOutput("resume_len", cyc, 256 - 20);
    checkOutput("resume_lit", hi, a_level - 20);
    a_level = nextLevel(a_level, 1'b1);

    // Complete the ramp to saturation and hold there
    while (a_level < 255) aPeriod("ramp255");
    aPeriod("sat_255");
    aPeriod("sat_hold");

    // Global scaling at full level
    applyStimulus(8'h01, 8'd128, 1'b1);
    aPeriod("gl_128");
    applyStimulus(8'h01, 8'd0, 1'b1);
    aPeriod("gl_0");
    applyStimulus(8'h01, 8'd200, 1'b1);
    aPeriod("gl_200");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
